// File: rtl/ladder_counter_updown_if.sv
// Bundle of control inputs and count outputs for the ladder counter.
// The master side drives requests/configuration; the slave side is the counter.
interface ladder_counter_updown_if #(
  parameter int WIDTH = 8
);
  logic             clk_in;
  logic             pulse_up;
  logic             pulse_down;
  logic             set;
  logic [WIDTH-1:0] presetValue;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             borrow;
  logic             at_max;
  logic             at_zero;

  modport master (
    output clk_in, pulse_up, pulse_down, set, presetValue, limit,
    input  out, carry, borrow, at_max, at_zero
  );

  modport slave (
    input  clk_in, pulse_up, pulse_down, set, presetValue, limit,
    output out, carry, borrow, at_max, at_zero
  );
endinterface

// File: rtl/ladder_counter_updown.sv
// Up/down ladder counter. Edge-detected up/down requests are buffered and applied
// on the next rising edge of the slow tick clk_in; everything runs on qzt_clk.
// A limit of 0 means the full 2^WIDTH range (the top value wraps to all ones).
module ladder_counter_updown #(
  parameter int               WIDTH       = 8,
  parameter bit               SATURATE    = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic              qzt_clk,
  input logic              reset,
  ladder_counter_updown_if.slave bus
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             clk_in_old;
  logic             up_old;
  logic             down_old;
  logic             pending_up;
  logic             pending_down;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_dly;
  logic             carry_q;
  logic             borrow_q;

  logic             up_edge;
  logic             down_edge;
  logic             tick;
  logic             req_up;
  logic             req_dn;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] next_count;
  logic             next_pending_up;
  logic             next_pending_down;
  logic             next_carry;
  logic             next_borrow;

  assign up_edge   = bus.pulse_up & ~up_old;
  assign down_edge = bus.pulse_down & ~down_old;
  assign tick      = bus.clk_in & ~clk_in_old;
  assign req_up    = pending_up | up_edge;
  assign req_dn    = pending_down | down_edge;
  // Highest legal value; limit==0 naturally yields all ones (2^WIDTH - 1).
  assign top       = bus.limit - ONE;

  // Next-state decision: set beats tick, tick beats idle buffering.
  always_comb begin
    next_count        = count;
    next_carry        = 1'b0;
    next_borrow       = 1'b0;
    next_pending_up   = pending_up | up_edge;
    next_pending_down = pending_down | down_edge;
    if (bus.set) begin
      next_count        = (bus.presetValue > top) ? top : bus.presetValue;
      next_pending_up   = 1'b0;
      next_pending_down = 1'b0;
    end else if (tick) begin
      next_pending_up   = 1'b0;
      next_pending_down = 1'b0;
      if (req_up && !req_dn) begin
        if (count < top) begin
          next_count = count + ONE;
        end else begin
          next_carry = 1'b1;
          next_count = SATURATE ? top : '0;
        end
      end else if (req_dn && !req_up) begin
        if (count == '0) begin
          next_borrow = 1'b1;
          next_count  = SATURATE ? '0 : top;
        end else if (count > top) begin
          // limit was lowered below the current value: snap to the new top
          next_count = top;
        end else begin
          next_count = count - ONE;
        end
      end
    end
  end

  // State registers, including edge-detect history and one-cycle carry/borrow.
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      clk_in_old   <= 1'b0;
      up_old       <= 1'b0;
      down_old     <= 1'b0;
      pending_up   <= 1'b0;
      pending_down <= 1'b0;
      count        <= RESET_VALUE;
      count_dly    <= RESET_VALUE;
      carry_q      <= 1'b0;
      borrow_q     <= 1'b0;
    end else begin
      clk_in_old   <= bus.clk_in;
      up_old       <= bus.pulse_up;
      down_old     <= bus.pulse_down;
      pending_up   <= next_pending_up;
      pending_down <= next_pending_down;
      count        <= next_count;
      count_dly    <= count;
      carry_q      <= next_carry;
      borrow_q     <= next_borrow;
    end
  end

  // Status flags come from the delayed copy of the count so they lag out by
  // one cycle, and their reset value follows RESET_VALUE without needing an
  // asynchronous load that depends on the limit input.
  assign bus.out     = count;
  assign bus.carry   = carry_q;
  assign bus.borrow  = borrow_q;
  assign bus.at_max  = (count_dly == top);
  assign bus.at_zero = (count_dly == '0);
endmodule

// File: tb/tb_ladder_counter_updown.sv
// Testbench: wrap-mode and saturate-mode counters driven by identical stimulus,
// checked against a behavioural model of the counting rules.
module tb_ladder_counter_updown;
  logic       qzt_clk = 1'b0;
  logic       reset;
  logic       clk_in, pulse_up, pulse_down, set;
  logic [7:0] preset_value, limit;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // model state
  int mw, ms;              // expected count, wrap and saturate builds
  bit pu, pd;              // requests buffered since last tick/set
  bit cw, bw, cs, bs;      // expected carry/borrow after the last tick

  ladder_counter_updown_if #(.WIDTH(8)) bus_w ();
  ladder_counter_updown_if #(.WIDTH(8)) bus_s ();

  assign bus_w.clk_in = clk_in;       assign bus_s.clk_in = clk_in;
  assign bus_w.pulse_up = pulse_up;   assign bus_s.pulse_up = pulse_up;
  assign bus_w.pulse_down = pulse_down; assign bus_s.pulse_down = pulse_down;
  assign bus_w.set = set;             assign bus_s.set = set;
  assign bus_w.presetValue = preset_value; assign bus_s.presetValue = preset_value;
  assign bus_w.limit = limit;         assign bus_s.limit = limit;

  ladder_counter_updown #(.WIDTH(8), .SATURATE(1'b0), .RESET_VALUE(8'd0)) dut_w (
    .qzt_clk(qzt_clk), .reset(reset), .bus(bus_w.slave));
  ladder_counter_updown #(.WIDTH(8), .SATURATE(1'b1), .RESET_VALUE(8'd0)) dut_s (
    .qzt_clk(qzt_clk), .reset(reset), .bus(bus_s.slave));

  always #5 qzt_clk = ~qzt_clk;

  function automatic int eff_lim();
    return (limit == 8'd0) ? 256 : int'(limit);
  endfunction

  // Counting rules in plain integer arithmetic.
  task automatic model_step(input int o, input bit up, input bit dn, input bit sat,
                            output int no, output bit c, output bit b);
    int eff;
    eff = eff_lim();
    no = o; c = 1'b0; b = 1'b0;
    if (up && !dn) begin
      if (o < eff - 1) no = o + 1;
      else begin c = 1'b1; no = sat ? eff - 1 : 0; end
    end else if (dn && !up) begin
      if (o == 0) begin b = 1'b1; no = sat ? 0 : eff - 1; end
      else if (o >= eff) no = eff - 1;
      else no = o - 1;
    end
  endtask

  task automatic cyc();
    @(posedge qzt_clk);
    #1;
  endtask

  task automatic do_up();
    pulse_up = 1'b1; cyc(); pulse_up = 1'b0; cyc(); pu = 1'b1;
  endtask

  task automatic do_down();
    pulse_down = 1'b1; cyc(); pulse_down = 1'b0; cyc(); pd = 1'b1;
  endtask

  task automatic do_both();
    pulse_up = 1'b1; pulse_down = 1'b1; cyc();
    pulse_up = 1'b0; pulse_down = 1'b0; cyc();
    pu = 1'b1; pd = 1'b1;
  endtask

  // Tick rising edge, optionally with up/down edges in the same cycle.
  task automatic do_tick(input bit eu, input bit ed);
    int nw, ns;
    pulse_up = eu; pulse_down = ed; clk_in = 1'b1;
    cyc();
    model_step(mw, pu | eu, pd | ed, 1'b0, nw, cw, bw);
    model_step(ms, pu | eu, pd | ed, 1'b1, ns, cs, bs);
    mw = nw; ms = ns; pu = 1'b0; pd = 1'b0;
    clk_in = 1'b0; pulse_up = 1'b0; pulse_down = 1'b0;
  endtask

  task automatic do_set(input int v);
    set = 1'b1; preset_value = 8'(v);
    cyc();
    set = 1'b0;
    mw = (v > eff_lim() - 1) ? eff_lim() - 1 : v;
    ms = mw; pu = 1'b0; pd = 1'b0;
    cw = 1'b0; bw = 1'b0; cs = 1'b0; bs = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; limit = 8'd10;
    cyc(); cyc();
    total_cnt++; if (bus_w.out === 8'd0) pass_cnt++; else $display("FAIL reset_out_w got=%0d want=0", bus_w.out);
    total_cnt++; if ({bus_s.carry, bus_s.borrow} === 2'b00) pass_cnt++; else $display("FAIL reset_cb_s got=%b want=00", {bus_s.carry, bus_s.borrow});
    total_cnt++; if ({bus_w.at_max, bus_w.at_zero} === 2'b01) pass_cnt++; else $display("FAIL reset_flags_w got=%b want=01", {bus_w.at_max, bus_w.at_zero});
    reset = 1'b0;
    cyc();
    mw = 0; ms = 0; pu = 1'b0; pd = 1'b0;
    total_cnt++; if (bus_s.out === 8'd0) pass_cnt++; else $display("FAIL reset_out_s got=%0d want=0", bus_s.out);
  endtask

  task automatic test_wrap_up();
    limit = 8'd10;
    do_set(8);
    do_up(); do_tick(1'b0, 1'b0); cyc();
    total_cnt++; if ({bus_w.out, bus_w.carry} === {8'd9, 1'b0}) pass_cnt++; else $display("FAIL wrap_up_9 got=%0d/%b want=9/0", bus_w.out, bus_w.carry);
    do_up(); do_tick(1'b0, 1'b0);
    total_cnt++; if ({bus_w.out, bus_w.carry} === {8'd0, 1'b1}) pass_cnt++; else $display("FAIL wrap_up_carry_w got=%0d/%b want=0/1", bus_w.out, bus_w.carry);
    total_cnt++; if ({bus_s.out, bus_s.carry} === {8'd9, 1'b1}) pass_cnt++; else $display("FAIL wrap_up_carry_s got=%0d/%b want=9/1", bus_s.out, bus_s.carry);
    cyc();
    total_cnt++; if ({bus_w.carry, bus_s.carry} === 2'b00) pass_cnt++; else $display("FAIL carry_one_cycle got=%b want=00", {bus_w.carry, bus_s.carry});
    total_cnt++; if ({bus_w.at_zero, bus_s.at_max} === 2'b11) pass_cnt++; else $display("FAIL wrap_flags got=%b want=11", {bus_w.at_zero, bus_s.at_max});
  endtask

  task automatic test_borrow();
    limit = 8'd10;
    do_set(0);
    do_down(); do_tick(1'b0, 1'b0);
    total_cnt++; if ({bus_w.out, bus_w.borrow} === {8'd9, 1'b1}) pass_cnt++; else $display("FAIL borrow_w got=%0d/%b want=9/1", bus_w.out, bus_w.borrow);
    total_cnt++; if ({bus_s.out, bus_s.borrow} === {8'd0, 1'b1}) pass_cnt++; else $display("FAIL borrow_s got=%0d/%b want=0/1", bus_s.out, bus_s.borrow);
    cyc();
    total_cnt++; if ({bus_w.borrow, bus_s.borrow} === 2'b00) pass_cnt++; else $display("FAIL borrow_one_cycle got=%b want=00", {bus_w.borrow, bus_s.borrow});
  endtask

  task automatic test_collapse();
    limit = 8'd10;
    do_set(3);
    do_up(); do_up(); do_up(); do_tick(1'b0, 1'b0); cyc();
    total_cnt++; if (bus_w.out === 8'd4) pass_cnt++; else $display("FAIL collapse_up got=%0d want=4", bus_w.out);
    do_up(); do_down(); do_tick(1'b0, 1'b0);
    total_cnt++; if ({bus_w.out, bus_w.carry, bus_w.borrow} === {8'd4, 2'b00}) pass_cnt++; else $display("FAIL cancel got=%0d/%b%b want=4/00", bus_w.out, bus_w.carry, bus_w.borrow);
    cyc();
    do_tick(1'b1, 1'b0); cyc();
    total_cnt++; if (bus_s.out === 8'd5) pass_cnt++; else $display("FAIL same_cycle_edge got=%0d want=5", bus_s.out);
  endtask

  task automatic test_set_priority();
    limit = 8'd10;
    do_set(200);
    total_cnt++; if ({bus_w.out, bus_s.out} === {8'd9, 8'd9}) pass_cnt++; else $display("FAIL set_clamp got=%0d,%0d want=9,9", bus_w.out, bus_s.out);
    do_up();
    set = 1'b1; preset_value = 8'd2; clk_in = 1'b1;
    cyc();
    set = 1'b0; clk_in = 1'b0;
    mw = 2; ms = 2; pu = 1'b0;
    total_cnt++; if ({bus_w.out, bus_w.carry} === {8'd2, 1'b0}) pass_cnt++; else $display("FAIL set_wins got=%0d/%b want=2/0", bus_w.out, bus_w.carry);
    cyc();
    do_tick(1'b0, 1'b0); cyc();
    total_cnt++; if (bus_w.out === 8'd2) pass_cnt++; else $display("FAIL set_clears_pending got=%0d want=2", bus_w.out);
  endtask

  task automatic test_async_reset();
    limit = 8'd10;
    do_set(5);
    do_up();
    @(posedge qzt_clk); #3;
    reset = 1'b1;
    #1;
    total_cnt++; if ({bus_w.out, bus_s.out} === 16'd0) pass_cnt++; else $display("FAIL async_reset got=%0d,%0d want=0,0", bus_w.out, bus_s.out);
    cyc();
    reset = 1'b0;
    mw = 0; ms = 0; pu = 1'b0; pd = 1'b0;
    cyc();
    do_tick(1'b0, 1'b0);
    total_cnt++; if ({bus_w.out, bus_w.carry} === {8'd0, 1'b0}) pass_cnt++; else $display("FAIL reset_discards_pending got=%0d/%b want=0/0", bus_w.out, bus_w.carry);
    cyc();
  endtask

  task automatic test_limits();
    limit = 8'd0;
    do_set(255);
    do_up(); do_tick(1'b0, 1'b0);
    total_cnt++; if ({bus_w.out, bus_w.carry, bus_s.out, bus_s.carry} === {8'd0, 1'b1, 8'd255, 1'b1}) pass_cnt++;
    else $display("FAIL limit0_up got=%0d/%b,%0d/%b want=0/1,255/1", bus_w.out, bus_w.carry, bus_s.out, bus_s.carry);
    cyc();
    limit = 8'd1;
    do_set(7);
    do_up(); do_tick(1'b0, 1'b0);
    total_cnt++; if ({bus_w.out, bus_w.carry} === {8'd0, 1'b1}) pass_cnt++; else $display("FAIL limit1_up got=%0d/%b want=0/1", bus_w.out, bus_w.carry);
    cyc();
    do_down(); do_tick(1'b0, 1'b0);
    total_cnt++; if ({bus_w.out, bus_w.borrow, bus_s.out, bus_s.borrow} === {8'd0, 1'b1, 8'd0, 1'b1}) pass_cnt++;
    else $display("FAIL limit1_down got=%0d/%b,%0d/%b want=0/1,0/1", bus_w.out, bus_w.borrow, bus_s.out, bus_s.borrow);
    cyc();
  endtask

  task automatic test_random();
    int r;
    bit checked;
    logic [9:0] exp_w, exp_s;
    logic [3:0] fl_w, fl_s;
    limit = 8'd10;
    do_set(0);
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 11);
      checked = 1'b0;
      case (r)
        0, 1, 2: do_up();
        3, 4:    do_down();
        5:       do_both();
        6, 7, 8: begin do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))); checked = 1'b1; end
        9:       begin do_set($urandom_range(0, 255)); checked = 1'b1; end
        default: begin
          case ($urandom_range(0, 4))
            0: limit = 8'd0;
            1: limit = 8'd1;
            2: limit = 8'd10;
            default: limit = 8'($urandom_range(1, 255));
          endcase
          cyc();
        end
      endcase
      if (checked) begin
        exp_w = {8'(mw), cw, bw};
        exp_s = {8'(ms), cs, bs};
        total_cnt++; if ({bus_w.out, bus_w.carry, bus_w.borrow} === exp_w) pass_cnt++;
        else $display("FAIL rand_w it=%0d got=%0d/%b%b want=%0d/%b%b", i, bus_w.out, bus_w.carry, bus_w.borrow, mw, cw, bw);
        total_cnt++; if ({bus_s.out, bus_s.carry, bus_s.borrow} === exp_s) pass_cnt++;
        else $display("FAIL rand_s it=%0d got=%0d/%b%b want=%0d/%b%b", i, bus_s.out, bus_s.carry, bus_s.borrow, ms, cs, bs);
        cyc();
        fl_w = {mw == eff_lim() - 1, mw == 0, 2'b00};
        fl_s = {ms == eff_lim() - 1, ms == 0, 2'b00};
        total_cnt++; if ({bus_w.at_max, bus_w.at_zero, bus_w.carry, bus_w.borrow} === fl_w) pass_cnt++;
        else $display("FAIL rand_flags_w it=%0d got=%b want=%b", i, {bus_w.at_max, bus_w.at_zero, bus_w.carry, bus_w.borrow}, fl_w);
        total_cnt++; if ({bus_s.at_max, bus_s.at_zero, bus_s.carry, bus_s.borrow} === fl_s) pass_cnt++;
        else $display("FAIL rand_flags_s it=%0d got=%b want=%b", i, {bus_s.at_max, bus_s.at_zero, bus_s.carry, bus_s.borrow}, fl_s);
      end
    end
  endtask

  initial begin
    reset = 1'b1; clk_in = 1'b0; pulse_up = 1'b0; pulse_down = 1'b0;
    set = 1'b0; preset_value = 8'd0; limit = 8'd10;
    mw = 0; ms = 0; pu = 1'b0; pd = 1'b0;
    cw = 1'b0; bw = 1'b0; cs = 1'b0; bs = 1'b0;
    test_reset();
    test_wrap_up();
    test_borrow();
    test_collapse();
    test_set_priority();
    test_async_reset();
    test_limits();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
